gearbox_ctrl_param: RTL and testbench

- Parametrised gear selector controller: sequence P, R, N, G1..G<NUM_GEARS>; gear count configurable from 1 to 9.
- Conditions raw shift buttons internally: synchroniser, debounce, rising-edge detect. Each clean press gives exactly one shift request.
- Adds three checks on every request: speed interlock, brake interlock, post-shift cooldown. Refused requests are flagged.
- Drives the gear-indicator 7-segment display and a binary gear code for downstream logic.

---
 rtl/gearbox_ctrl_param.sv | 168 ++++++++++++++++
 tb/tb_gearbox_ctrl_param.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gearbox_ctrl_param.sv
// rtl/gearbox_ctrl_param.sv - gear selector with conditioned shift buttons, interlocks and 7-segment indicator
module gearbox_ctrl_param #(
   parameter int NUM_GEARS       = 6,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SHIFT_LOCK      = 8,
   parameter int SPEED_W         = 8,
   parameter int VMAX_STEP       = 30
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               shift_up,
   input  logic               shift_down,
   input  logic               brake,
   input  logic [SPEED_W-1:0] speed,
   output logic [6:0]         seg,
   output logic [3:0]         gear,
   output logic               shift_event,
   output logic               reject,
   output logic               locked
);
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int LW = (SHIFT_LOCK > 0) ? $clog2(SHIFT_LOCK + 1) : 1;
   localparam int MW = SPEED_W + 4;
   localparam logic [3:0]    TOP       = 4'(2 + NUM_GEARS);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LW-1:0] LOCK_LOAD = LW'(SHIFT_LOCK);
   localparam logic [MW-1:0] STEP      = MW'(VMAX_STEP);

   typedef enum logic [3:0] {
      ST_P  = 4'd0,  ST_R  = 4'd1,  ST_N  = 4'd2,
      ST_G1 = 4'd3,  ST_G2 = 4'd4,  ST_G3 = 4'd5,  ST_G4 = 4'd6,  ST_G5 = 4'd7,
      ST_G6 = 4'd8,  ST_G7 = 4'd9,  ST_G8 = 4'd10, ST_G9 = 4'd11
   } state_t;

   state_t        state, state_nxt;
   logic [3:0]    code;
   logic [2:0]    s1, s2;          // {brake, down, up}
   logic [1:0]    req;             // {down, up}
   logic [LW-1:0] lock_cnt;
   logic          accept, refuse;
   logic [MW-1:0] speed_ext, limit;

   // Active-low indicator pattern for a state code; codes beyond the top gear are blank.
   function automatic logic [6:0] seg_of(input logic [3:0] c);
      logic [6:0] on;
      case (c)
         4'd0:    on = 7'b1110011;
         4'd1:    on = 7'b1010000;
         4'd2:    on = 7'b1010100;
         4'd3:    on = 7'b0000110;
         4'd4:    on = 7'b1011011;
         4'd5:    on = 7'b1001111;
         4'd6:    on = 7'b1100110;
         4'd7:    on = 7'b1101101;
         4'd8:    on = 7'b1111101;
         4'd9:    on = 7'b0000111;
         4'd10:   on = 7'b1111111;
         4'd11:   on = 7'b1101111;
         default: on = 7'b0000000;
      endcase
      if (c > TOP) on = 7'b0000000;
      return ~on;
   endfunction

   // Two-flop synchronisers for the asynchronous buttons and brake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= {brake, shift_down, shift_up};
         s2 <= s1;
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_deb
      logic [DW-1:0] cnt;
      logic          deb, deb_q;

      // Clean level follows the synchronised input only after it has differed for DEBOUNCE_CYCLES samples.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt   <= '0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
         end else begin
            deb_q <= deb;
            if (s2[i] == deb) begin
               cnt <= '0;
            end else if (cnt == DEB_LAST) begin
               cnt <= '0;
               deb <= s2[i];
            end else begin
               cnt <= cnt + DW'(1);
            end
         end
      end

      assign req[i] = deb & ~deb_q;
   end

   assign code      = state;
   assign speed_ext = MW'(speed);
   assign limit     = STEP * MW'(code - 4'd3);

   // Arbitrate requests and apply the interlock rules to pick the next state.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      refuse    = 1'b0;
      if (code > TOP) begin
         state_nxt = ST_P;
         refuse    = req[0] | req[1];
      end else if (req[0] | req[1]) begin
         if ((req[0] & req[1]) || (lock_cnt != '0)) begin
            refuse = 1'b1;
         end else begin
            case (state)
               ST_P: begin
                  if (req[0] && s2[2] && speed == '0) state_nxt = ST_R;
               end
               ST_R: begin
                  if (req[0] && s2[2] && speed == '0)      state_nxt = ST_N;
                  else if (req[1] && s2[2] && speed == '0) state_nxt = ST_P;
               end
               ST_N: begin
                  if (req[0])                              state_nxt = ST_G1;
                  else if (req[1] && s2[2] && speed == '0) state_nxt = ST_R;
               end
               default: begin
                  // Forward gears: G1 drops to N at any speed, higher gears need speed within the target gear's limit.
                  if (req[0]) begin
                     if (code < TOP) state_nxt = state_t'(code + 4'd1);
                  end else if (state == ST_G1 || speed_ext <= limit) begin
                     state_nxt = state_t'(code - 4'd1);
                  end
               end
            endcase
            accept = (state_nxt != state);
            refuse = (state_nxt == state);
         end
      end
   end

   // State, indicator, result pulses and cooldown counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_P;
         seg         <= 7'b0001100;
         shift_event <= 1'b0;
         reject      <= 1'b0;
         lock_cnt    <= '0;
      end else begin
         state       <= state_nxt;
         seg         <= seg_of(state_nxt);
         shift_event <= accept;
         reject      <= refuse;
         if (accept)
            lock_cnt <= LOCK_LOAD;
         else if (lock_cnt != '0)
            lock_cnt <= lock_cnt - LW'(1);
      end
   end

   assign gear   = state;
   assign locked = (lock_cnt != '0);

endmodule

// File: tb/tb_gearbox_ctrl_param.sv
// tb/tb_gearbox_ctrl_param.sv - bench for gearbox_ctrl_param (6- and 9-gear instances on shared inputs)
module tb_gearbox_ctrl_param;
   localparam int D  = 4;
   localparam int SL = 8;
   localparam int VS = 30;

   logic       clk = 1'b0;
   logic       reset, shift_up, shift_down, brake;
   logic [7:0] speed;
   logic [6:0] seg_a, seg_b;
   logic [3:0] gear_a, gear_b;
   logic       shift_event_a, shift_event_b, reject_a, reject_b, locked_a, locked_b;

   gearbox_ctrl_param dut_a (
      .clk(clk), .reset(reset), .shift_up(shift_up), .shift_down(shift_down), .brake(brake),
      .speed(speed), .seg(seg_a), .gear(gear_a), .shift_event(shift_event_a),
      .reject(reject_a), .locked(locked_a));

   gearbox_ctrl_param #(.NUM_GEARS(9)) dut_b (
      .clk(clk), .reset(reset), .shift_up(shift_up), .shift_down(shift_down), .brake(brake),
      .speed(speed), .seg(seg_b), .gear(gear_b), .shift_event(shift_event_b),
      .reject(reject_b), .locked(locked_b));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ev_a = 0, ev_b = 0, rj_a = 0, rj_b = 0;

   // reference model: raw input history (oldest first), debounced levels, gear codes per instance
   bit hu[$], hd[$], hb[$];
   bit deb_u, deb_d, rq_u, rq_d;
   int ms[2], last_acc[2], mev[2], mrj[2];
   int ngs[2] = '{6, 9};
   int spd_list[10] = '{0, 30, 31, 60, 61, 90, 91, 150, 151, 255};

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] seg_exp(input int c, input int ng);
      logic [6:0] p;
      case (c)
         0: p = 7'b1110011;  1: p = 7'b1010000;  2: p = 7'b1010100;
         3: p = 7'b0000110;  4: p = 7'b1011011;  5: p = 7'b1001111;
         6: p = 7'b1100110;  7: p = 7'b1101101;  8: p = 7'b1111101;
         9: p = 7'b0000111; 10: p = 7'b1111111; 11: p = 7'b1101111;
         default: p = 7'b0000000;
      endcase
      if (c > ng + 2) p = 7'b0000000;
      return ~p;
   endfunction

   // gear rules: returns the target state code, or the same code when the request is refused
   function automatic int rule(input int c, input bit up, input bit dn, input bit b,
                               input int spd, input int ng);
      bit ok_slow;
      int k;
      ok_slow = b && (spd == 0);
      k = c - 2;
      if (up && dn) return c;
      if (c == 0) return (up && ok_slow) ? 1 : 0;
      if (c == 1) return (up && ok_slow) ? 2 : ((dn && ok_slow) ? 0 : 1);
      if (c == 2) return up ? 3 : ((dn && ok_slow) ? 1 : 2);
      if (up) return (k < ng) ? c + 1 : c;
      if (k == 1) return 2;
      return (spd <= VS * (k - 1)) ? c - 1 : c;
   endfunction

   function automatic void model_reset();
      hu.delete(); hd.delete(); hb.delete();
      for (int i = 0; i < D + 2; i++) begin
         hu.push_back(1'b0); hd.push_back(1'b0); hb.push_back(1'b0);
      end
      deb_u = 0; deb_d = 0; rq_u = 0; rq_d = 0;
      for (int i = 0; i < 2; i++) begin
         ms[i] = 0; last_acc[i] = -1000; mev[i] = 0; mrj[i] = 0;
      end
   endfunction

   // one clock edge: inputs reach the logic two samples late; a level flips after D equal opposite samples
   function automatic void model_edge(input int n);
      bit all_u, all_d;
      int nxt;
      hu.push_back(shift_up); hd.push_back(shift_down); hb.push_back(brake);
      void'(hu.pop_front()); void'(hd.pop_front()); void'(hb.pop_front());
      for (int i = 0; i < 2; i++) begin
         mev[i] = 0; mrj[i] = 0;
         if (rq_u || rq_d) begin
            if (n - last_acc[i] <= SL) nxt = ms[i];
            else nxt = rule(ms[i], rq_u, rq_d, hb[D-1], int'(speed), ngs[i]);
            if (nxt != ms[i]) begin
               mev[i] = 1; ms[i] = nxt; last_acc[i] = n;
            end else begin
               mrj[i] = 1;
            end
         end
      end
      all_u = 1; all_d = 1;
      for (int j = 0; j < D; j++) begin
         if (hu[j] == deb_u) all_u = 0;
         if (hd[j] == deb_d) all_d = 0;
      end
      rq_u = all_u && !deb_u;
      rq_d = all_d && !deb_d;
      if (all_u) deb_u = !deb_u;
      if (all_d) deb_d = !deb_d;
   endfunction

   task automatic step();
      @(posedge clk);
      cyc++;
      if (reset) model_reset();
      else model_edge(cyc);
      #1;
      if (shift_event_a === 1'b1) ev_a++;
      if (shift_event_b === 1'b1) ev_b++;
      if (reject_a === 1'b1) rj_a++;
      if (reject_b === 1'b1) rj_b++;
      check("a.gear",   16'(gear_a),        16'(ms[0]));
      check("a.seg",    16'(seg_a),         16'(seg_exp(ms[0], 6)));
      check("a.event",  16'(shift_event_a), 16'(mev[0]));
      check("a.reject", 16'(reject_a),      16'(mrj[0]));
      check("a.locked", 16'(locked_a),      16'((cyc - last_acc[0]) < SL));
      check("b.gear",   16'(gear_b),        16'(ms[1]));
      check("b.seg",    16'(seg_b),         16'(seg_exp(ms[1], 9)));
      check("b.event",  16'(shift_event_b), 16'(mev[1]));
      check("b.reject", 16'(reject_b),      16'(mrj[1]));
      check("b.locked", 16'(locked_b),      16'((cyc - last_acc[1]) < SL));
   endtask

   task automatic press(input bit up, input bit dn, input int hold, input int gap);
      shift_up = up; shift_down = dn;
      repeat (hold) step();
      shift_up = 0; shift_down = 0;
      repeat (gap) step();
   endtask

   initial begin
      int e0, r0, act, hold, gap;
      reset = 1; shift_up = 0; shift_down = 0; brake = 0; speed = 0;
      model_reset();
      repeat (3) step();
      check("rst.gear",   16'(gear_a),        16'd0);
      check("rst.seg",    16'(seg_a),         16'(7'b0001100));
      check("rst.event",  16'(shift_event_a), 16'd0);
      check("rst.reject", 16'(reject_a),      16'd0);
      check("rst.locked", 16'(locked_a),      16'd0);
      reset = 0; brake = 1; speed = 0;
      repeat (6) step();

      // three clean up presses: P -> R -> N -> G1, each decided at edge 7
      for (int p = 1; p <= 3; p++) begin
         e0 = ev_a;
         shift_up = 1;
         repeat (6) step();
         check("t1.no_early_event", 16'(ev_a - e0), 16'd0);
         step();
         check("t1.event_edge7", 16'(shift_event_a), 16'd1);
         check("t1.gear", 16'(gear_a), 16'(p));
         repeat (3) step();
         shift_up = 0;
         repeat (10) step();
      end
      check("t1.seg_g1", 16'(seg_a), 16'(7'b1111001));

      // back to N, then a 2-cycle glitch must be ignored
      press(0, 1, 10, 12);
      check("t2.gear_n", 16'(gear_a), 16'd2);
      e0 = ev_a; r0 = rj_a;
      press(1, 0, 2, 15);
      check("t2.glitch_event", 16'(ev_a - e0), 16'd0);
      check("t2.glitch_reject", 16'(rj_a - r0), 16'd0);
      check("t2.gear", 16'(gear_a), 16'd2);

      // into G1, then one long hold gives exactly one upshift
      press(1, 0, 10, 12);
      e0 = ev_a;
      press(1, 0, 50, 15);
      check("t3.single_event", 16'(ev_a - e0), 16'd1);
      check("t3.gear", 16'(gear_a), 16'd4);

      // G3 downshift speed limit is 60
      press(1, 0, 10, 12);
      check("t4.gear_g3", 16'(gear_a), 16'd5);
      speed = 61; r0 = rj_a;
      press(0, 1, 10, 12);
      check("t4.fast_reject", 16'(rj_a - r0), 16'd1);
      check("t4.fast_gear", 16'(gear_a), 16'd5);
      speed = 60;
      press(0, 1, 10, 12);
      check("t4.limit_gear", 16'(gear_a), 16'd4);
      speed = 0;

      // up request decided 4 cycles after an accepted downshift is refused by the cooldown
      shift_down = 1;
      repeat (4) step();
      shift_up = 1;
      repeat (3) step();
      check("t5.first_event", 16'(shift_event_a), 16'd1);
      check("t5.first_gear", 16'(gear_a), 16'd3);
      repeat (3) step();
      check("t5.locked", 16'(locked_a), 16'd1);
      step();
      check("t5.reject", 16'(reject_a), 16'd1);
      check("t5.gear_kept", 16'(gear_a), 16'd3);
      shift_up = 0; shift_down = 0;
      repeat (20) step();
      check("t5.unlocked", 16'(locked_a), 16'd0);
      press(1, 0, 10, 12);
      check("t5.after_lock", 16'(gear_a), 16'd4);

      // 9-gear instance climbs to G9; the 6-gear instance saturates at G6
      repeat (7) press(1, 0, 10, 12);
      check("t6.b_g9", 16'(gear_b), 16'd11);
      check("t6.a_g6", 16'(gear_a), 16'd8);
      r0 = rj_b;
      press(1, 0, 10, 12);
      check("t6.top_reject", 16'(rj_b - r0), 16'd1);
      check("t6.top_gear", 16'(gear_b), 16'd11);
      check("t6.top_seg", 16'(seg_b), 16'(7'b0010000));

      // reset 2 cycles into a debounce abandons the press
      shift_up = 1;
      repeat (2) step();
      reset = 1; shift_up = 0;
      repeat (3) step();
      check("t6.rst_gear", 16'(gear_b), 16'd0);
      check("t6.rst_seg", 16'(seg_b), 16'(7'b0001100));
      reset = 0;
      e0 = ev_b;
      repeat (20) step();
      check("t6.no_event", 16'(ev_b - e0), 16'd0);

      // randomized presses, glitches, bounce, speed and brake against the model
      for (int s = 0; s < 90; s++) begin
         act  = int'($urandom_range(0, 9));
         hold = int'($urandom_range(1, 14));
         gap  = int'($urandom_range(0, 12));
         speed = 8'(spd_list[$urandom_range(0, 9)]);
         brake = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 39) == 0) begin
            reset = 1;
            repeat (2) step();
            reset = 0;
         end
         for (int c = 0; c < hold; c++) begin
            case (act)
               0, 1, 2, 3: shift_up = 1;
               4, 5:       shift_down = 1;
               6:          begin shift_up = 1; shift_down = 1; end
               7:          shift_up = 1'($urandom_range(0, 1));
               8:          shift_down = 1'($urandom_range(0, 1));
               default:    begin shift_up = 0; shift_down = 0; end
            endcase
            step();
         end
         shift_up = 0; shift_down = 0;
         repeat (gap) step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
